// File: rtl/gray_mem_arbiter.sv
// Arbiter for the single-port gray image SRAM. The host loader writes a frame,
// then the LBP engine reads it through a 3-cycle issue/capture/grant handshake.
module gray_mem_arbiter #(
    parameter int AW = 14,
    parameter int DW = 8,
    parameter int FW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          host_wr_req,
    input  logic [AW-1:0] host_wr_addr,
    input  logic [DW-1:0] host_wr_data,
    output logic          host_wr_ack,
    input  logic          host_done,
    output logic          gray_ready,
    input  logic          gray_req,
    input  logic [AW-1:0] gray_addr,
    output logic [DW-1:0] gray_data,
    input  logic          lbp_finish,
    output logic          mem_cen,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          loading,
    output logic [FW-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        GRANT   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] gray_data_q, gray_data_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= LOAD;
            gray_data_q <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gray_data_q <= gray_data_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gray_data_d = gray_data_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            LOAD:    if (host_done) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: begin
                state_d     = GRANT;
                gray_data_d = mem_rdata;
            end
            GRANT:   if (gray_req) state_d = ISSUE;
            default: state_d = LOAD;
        endcase
        // Finish wins over everything in the run phase; an in-flight read is dropped.
        if (state_q != LOAD && lbp_finish) begin
            state_d     = LOAD;
            gray_data_d = gray_data_q;
            frame_cnt_d = frame_cnt_q + {{(FW-1){1'b0}}, 1'b1};
        end
    end

    // The engine owns the port in ISSUE; in every other state a host write goes through.
    always_comb begin
        host_wr_ack = 1'b0;
        mem_cen     = 1'b0;
        mem_wen     = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (state_q == ISSUE) begin
            mem_cen  = 1'b1;
            mem_addr = gray_addr;
        end else if (host_wr_req) begin
            host_wr_ack = 1'b1;
            mem_cen     = 1'b1;
            mem_wen     = 1'b1;
            mem_addr    = host_wr_addr;
            mem_wdata   = host_wr_data;
        end
    end

    assign gray_ready = (state_q == GRANT);
    assign loading    = (state_q == LOAD);
    assign gray_data  = gray_data_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_gray_mem_arbiter.sv
// Directed bench for gray_mem_arbiter with a behavioural 1-cycle-latency SRAM.
module tb_gray_mem_arbiter;

    localparam int AW = 14;
    localparam int DW = 8;
    localparam int FW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          host_wr_req;
    logic [AW-1:0] host_wr_addr;
    logic [DW-1:0] host_wr_data;
    logic          host_wr_ack;
    logic          host_done;
    logic          gray_ready;
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic [DW-1:0] gray_data;
    logic          lbp_finish;
    logic          mem_cen;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          loading;
    logic [FW-1:0] frame_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    gray_mem_arbiter #(.AW(AW), .DW(DW), .FW(FW)) dut (
        .clk          (clk),
        .reset        (reset),
        .host_wr_req  (host_wr_req),
        .host_wr_addr (host_wr_addr),
        .host_wr_data (host_wr_data),
        .host_wr_ack  (host_wr_ack),
        .host_done    (host_done),
        .gray_ready   (gray_ready),
        .gray_req     (gray_req),
        .gray_addr    (gray_addr),
        .gray_data    (gray_data),
        .lbp_finish   (lbp_finish),
        .mem_cen      (mem_cen),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .loading      (loading),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] sram [1 << AW];
    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_cen) begin
            if (mem_wen) sram[mem_addr] <= mem_wdata;
            else         mem_rdata <= sram[mem_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic done);
        host_wr_req  = 1'b1;
        host_wr_addr = a;
        host_wr_data = d;
        host_done    = done;
        #1;
        check_eq("wr_ack",   host_wr_ack, 1);
        check_eq("wr_cen",   mem_cen, 1);
        check_eq("wr_wen",   mem_wen, 1);
        check_eq("wr_addr",  mem_addr, a);
        check_eq("wr_wdata", mem_wdata, d);
        tick();
        host_wr_req = 1'b0;
        host_done   = 1'b0;
    endtask

    // Full fetch from GRANT: request, ISSUE, CAPTURE, back in GRANT.
    task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] exp_d);
        gray_addr = a;
        gray_req  = 1'b1;
        tick();
        gray_req = 1'b0;
        check_eq("iss_ready", gray_ready, 0);
        check_eq("iss_cen",   mem_cen, 1);
        check_eq("iss_wen",   mem_wen, 0);
        check_eq("iss_addr",  mem_addr, a);
        tick();
        check_eq("cap_ready", gray_ready, 0);
        tick();
        check_eq("grant_ready", gray_ready, 1);
        check_eq("grant_data",  gray_data, exp_d);
    endtask

    initial begin
        reset        = 1'b0;
        host_wr_req  = 1'b0;
        host_wr_addr = '0;
        host_wr_data = '0;
        host_done    = 1'b0;
        gray_req     = 1'b0;
        gray_addr    = '0;
        lbp_finish   = 1'b0;
        tick();
        tick();

        check_eq("rst_loading", loading, 1);
        check_eq("rst_ready",   gray_ready, 0);
        check_eq("rst_data",    gray_data, 0);
        check_eq("rst_frame",   frame_cnt, 0);
        check_eq("rst_cen",     mem_cen, 0);
        check_eq("rst_wen",     mem_wen, 0);
        check_eq("rst_addr",    mem_addr, 0);
        check_eq("rst_wdata",   mem_wdata, 0);
        check_eq("rst_ack",     host_wr_ack, 0);

        reset = 1'b1;
        tick();
        tick();
        check_eq("idle_loading", loading, 1);
        check_eq("idle_cen",     mem_cen, 0);

        // Load phase; the last write rides along with host_done.
        host_write(14'h0081, 8'h40, 1'b0);
        check_eq("load_stay", loading, 1);
        host_write(14'h0000, 8'h10, 1'b0);
        host_write(14'h0005, 8'h77, 1'b1);

        // First read uses the engine's un-reset address 0.
        check_eq("issue_loading", loading, 0);
        check_eq("issue_cen",     mem_cen, 1);
        check_eq("issue_addr",    mem_addr, 14'h0000);
        tick();
        check_eq("cap_idle_cen", mem_cen, 0);
        tick();
        check_eq("first_ready", gray_ready, 1);
        check_eq("first_data",  gray_data, 8'h10);

        fetch(14'h0081, 8'h40);

        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("stall_ready", gray_ready, 1);
            check_eq("stall_data",  gray_data, 8'h40);
            check_eq("stall_cen",   mem_cen, 0);
        end

        // Host contends with an engine read starting in ISSUE.
        gray_addr = 14'h0005;
        gray_req  = 1'b1;
        tick();
        gray_req     = 1'b0;
        host_wr_req  = 1'b1;
        host_wr_addr = 14'h0100;
        host_wr_data = 8'h5A;
        #1;
        check_eq("cont_iss_ack",  host_wr_ack, 0);
        check_eq("cont_iss_wen",  mem_wen, 0);
        check_eq("cont_iss_addr", mem_addr, 14'h0005);
        tick();
        check_eq("cont_cap_ack",   host_wr_ack, 1);
        check_eq("cont_cap_wen",   mem_wen, 1);
        check_eq("cont_cap_addr",  mem_addr, 14'h0100);
        check_eq("cont_cap_wdata", mem_wdata, 8'h5A);
        tick();
        host_wr_req = 1'b0;
        check_eq("cont_grant_data", gray_data, 8'h77);
        fetch(14'h0100, 8'h5A);

        // Finish beats a simultaneous gray_req.
        gray_addr  = 14'h0081;
        gray_req   = 1'b1;
        lbp_finish = 1'b1;
        tick();
        gray_req   = 1'b0;
        lbp_finish = 1'b0;
        check_eq("fin_loading", loading, 1);
        check_eq("fin_ready",   gray_ready, 0);
        check_eq("fin_frame",   frame_cnt, 1);
        check_eq("fin_cen",     mem_cen, 0);

        // host_done outside LOAD must be ignored; second frame finishes from ISSUE.
        host_done = 1'b1;
        tick();
        host_done = 1'b0;
        check_eq("f2_issue", loading, 0);
        lbp_finish = 1'b1;
        host_done  = 1'b1;
        tick();
        lbp_finish = 1'b0;
        host_done  = 1'b0;
        check_eq("f2_loading", loading, 1);
        check_eq("f2_frame",   frame_cnt, 2);
        tick();
        check_eq("f2_stay_load", loading, 1);

        // Async reset mid-run; SRAM contents survive.
        host_done = 1'b1;
        tick();
        host_done = 1'b0;
        tick();
        tick();
        check_eq("pre_rst_ready", gray_ready, 1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_loading", loading, 1);
        check_eq("arst_frame",   frame_cnt, 0);
        check_eq("arst_data",    gray_data, 0);
        tick();
        reset = 1'b1;
        tick();
        gray_addr = 14'h0081;
        host_done = 1'b1;
        tick();
        host_done = 1'b0;
        check_eq("post_rst_addr", mem_addr, 14'h0081);
        tick();
        tick();
        check_eq("post_rst_data", gray_data, 8'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
